// File: rtl/mem_burst_reader.sv
`timescale 1ns/1ps
// mem_burst_reader
//
// Sequential read master for a shared-bus memory. A burst is requested with
// a start address and a word count. For each word the reader selects the
// memory, waits ReadLatency cycles, captures the bus and presents the word
// on a valid/ready output stream.
//
// Ports:
//   Clock, Reset        rising-edge clock; asynchronous active-high reset
//   Tick                advance qualifier; nothing moves on edges with Tick=0
//   Start               burst request, accepted only in IDLE with Tick=1
//   StartAddr, Length   first address and word count, sampled on acceptance
//   Busy                burst in progress (cycle after acceptance through FIN)
//   Done                one-cycle pulse in the final (FIN) state
//   MemAddr, MemCs_n    registered memory address; active-low memory select
//   MemData             shared memory data bus (floats while deselected)
//   OutData, OutValid   captured word and its valid flag
//   OutReady            consumer accepts the word
//
// Output handshake: a word transfers on a rising edge where OutValid=1,
// OutReady=1 and Tick=1. While OutValid=1 and no transfer happens, OutData
// is held unchanged. OutReady has no effect while OutValid=0.
module mem_burst_reader #(
    parameter int NrOfBits    = 16,
    parameter int AddrBits    = 8,
    parameter int ReadLatency = 2
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                Start,
    input  logic [AddrBits-1:0] StartAddr,
    input  logic [AddrBits-1:0] Length,
    output logic                Busy,
    output logic                Done,
    output logic [AddrBits-1:0] MemAddr,
    output logic                MemCs_n,
    input  logic [NrOfBits-1:0] MemData,
    output logic [NrOfBits-1:0] OutData,
    output logic                OutValid,
    input  logic                OutReady
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    // ISSUE accounts for the first select cycle, so WAIT covers the rest.
    localparam logic [2:0] WAIT_INIT = 3'(ReadLatency - 1);

    state_t                state_q, state_d;
    logic [AddrBits-1:0]   mem_addr_q, mem_addr_d;
    logic [AddrBits-1:0]   remaining_q, remaining_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [NrOfBits-1:0]   out_data_q, out_data_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            wait_cnt_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            remaining_q <= remaining_d;
            wait_cnt_q  <= wait_cnt_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        remaining_d = remaining_q;
        wait_cnt_d  = wait_cnt_q;
        out_data_d  = out_data_q;
        if (Tick) begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        mem_addr_d  = StartAddr;
                        remaining_d = Length;
                        state_d     = (Length != '0) ? S_ISSUE : S_FIN;
                    end
                end
                S_ISSUE: begin
                    if (ReadLatency == 1) begin
                        out_data_d = MemData;
                        state_d    = S_HOLD;
                    end else begin
                        wait_cnt_d = WAIT_INIT;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The edge that takes the counter to zero is the sample edge.
                    if (wait_cnt_q <= 3'd1) begin
                        wait_cnt_d = '0;
                        out_data_d = MemData;
                        state_d    = S_HOLD;
                    end else begin
                        wait_cnt_d = wait_cnt_q - 3'd1;
                    end
                end
                S_HOLD: begin
                    if (OutReady) begin
                        remaining_d = remaining_q - AddrBits'(1);
                        mem_addr_d  = mem_addr_q + AddrBits'(1);
                        state_d     = (remaining_q != AddrBits'(1)) ? S_ISSUE : S_FIN;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the state register, so an asynchronous reset
    // releases the bus and drops every status flag immediately.
    assign Busy     = (state_q != S_IDLE);
    assign Done     = (state_q == S_FIN);
    assign OutValid = (state_q == S_HOLD);
    assign MemCs_n  = !((state_q == S_ISSUE) || (state_q == S_WAIT));
    assign MemAddr  = mem_addr_q;
    assign OutData  = out_data_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
`timescale 1ns/1ps
module tb_mem_burst_reader;
  localparam int NB = 16;
  localparam int AB = 8;

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  logic          Tick;
  logic          start0, start1;
  logic [AB-1:0] StartAddr, Length;
  logic          OutReady;

  logic          busy0, done0, cs_n0, valid0;
  logic [AB-1:0] addr0;
  logic [NB-1:0] odata0;
  wire  [NB-1:0] mdata0;
  logic          busy1, done1, cs_n1, valid1;
  logic [AB-1:0] addr1;
  logic [NB-1:0] odata1;
  wire  [NB-1:0] mdata1;

  int checks = 0;
  int errors = 0;

  mem_burst_reader #(.NrOfBits(NB), .AddrBits(AB), .ReadLatency(2)) dut_l2 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(start0),
    .StartAddr(StartAddr), .Length(Length), .Busy(busy0), .Done(done0),
    .MemAddr(addr0), .MemCs_n(cs_n0), .MemData(mdata0), .OutData(odata0),
    .OutValid(valid0), .OutReady(OutReady)
  );

  mem_burst_reader #(.NrOfBits(NB), .AddrBits(AB), .ReadLatency(3)) dut_l3 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(start1),
    .StartAddr(StartAddr), .Length(Length), .Busy(busy1), .Done(done1),
    .MemAddr(addr1), .MemCs_n(cs_n1), .MemData(mdata1), .OutData(odata1),
    .OutValid(valid1), .OutReady(OutReady)
  );

  // ---------------- memory model ----------------
  // Drives the bus only while selected; the stored word appears only once
  // the select has been held for the full latency, junk (~word) before that.
  logic [NB-1:0] mem [256];
  int cs_cnt0, cs_cnt1;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cs_cnt0 <= 0;
      cs_cnt1 <= 0;
    end else begin
      if (cs_n0) cs_cnt0 <= 0; else if (Tick) cs_cnt0 <= cs_cnt0 + 1;
      if (cs_n1) cs_cnt1 <= 0; else if (Tick) cs_cnt1 <= cs_cnt1 + 1;
    end
  end

  assign mdata0 = cs_n0 ? {NB{1'bz}} : ((cs_cnt0 >= 1) ? mem[addr0] : ~mem[addr0]);
  assign mdata1 = cs_n1 ? {NB{1'bz}} : ((cs_cnt1 >= 2) ? mem[addr1] : ~mem[addr1]);

  // ---------------- selected-DUT view ----------------
  logic sel = 1'b0;
  wire          s_busy  = sel ? busy1  : busy0;
  wire          s_done  = sel ? done1  : done0;
  wire          s_cs_n  = sel ? cs_n1  : cs_n0;
  wire          s_valid = sel ? valid1 : valid0;
  wire [AB-1:0] s_addr  = sel ? addr1  : addr0;
  wire [NB-1:0] s_odata = sel ? odata1 : odata0;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus safety: never selected while a word is being offered; Done only while busy.
  always @(negedge Clock) begin
    if (!Reset) begin
      checks++;
      assert (!((cs_n0 === 1'b0 && valid0 === 1'b1) || (cs_n1 === 1'b0 && valid1 === 1'b1))) else begin
        errors++;
        $error("FAIL cs_while_valid observed=%b%b/%b%b expected=no overlap", cs_n0, valid0, cs_n1, valid1);
      end
      checks++;
      assert (!((done0 === 1'b1 && busy0 !== 1'b1) || (done1 === 1'b1 && busy1 !== 1'b1))) else begin
        errors++;
        $error("FAIL done_without_busy observed=%b%b/%b%b expected=busy with done", done0, busy0, done1, busy1);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  s_busy,  0);
    chk({tag, "_done"},  s_done,  0);
    chk({tag, "_cs_n"},  s_cs_n,  1);
    chk({tag, "_addr"},  s_addr,  0);
    chk({tag, "_odata"}, s_odata, 0);
    chk({tag, "_valid"}, s_valid, 0);
  endtask

  // ---------------- burst driver + reference model ----------------
  // Reference: the words are mem[(addr+i) mod 256] in order; with Tick always
  // high each word costs L+1 cycles plus one per stalled edge; with Tick
  // toggling every phase costs twice as many cycles.
  task automatic run_burst(input bit s, input logic [AB-1:0] addr, input logic [AB-1:0] len,
                           input bit toggle, input int stall_first, input bit stall_rand,
                           input bit restart_mid, output int fin_cycle);
    logic [NB-1:0] exp_q[$];
    logic [AB-1:0] addr_q[$];
    logic [AB-1:0] a;
    int lat, mult, k, stall_total, words, cs_low, stall_left;
    sel = s;
    lat = s ? 3 : 2;
    mult = toggle ? 2 : 1;
    a = addr;
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(mem[a]);
      addr_q.push_back(a);
      a = a + 8'd1;
    end
    StartAddr = addr;
    Length = len;
    Tick = 1'b1;
    OutReady = 1'($urandom_range(0, 1));
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge Clock); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    StartAddr = 8'($urandom);
    Length = 8'($urandom);
    k = 1; fin_cycle = 0; stall_total = 0; words = 0; cs_low = 0; stall_left = stall_first;
    while (fin_cycle == 0 && k < 3000) begin
      if (s_cs_n === 1'b0) cs_low++;
      chk("busy_during_burst", s_busy, 1);
      if (s_done === 1'b1) begin
        fin_cycle = k;
      end else begin
        Tick = toggle ? (k % 2 == 0) : 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (s_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("out_valid_unexpected", s_valid, 0);
            OutReady = 1'b1;
          end else begin
            chk("out_data", s_odata, exp_q[0]);
            chk("mem_addr", s_addr, addr_q[0]);
            if (stall_left > 0 || (stall_rand && $urandom_range(0, 3) == 0)) begin
              OutReady = 1'b0;
              if (stall_left > 0) stall_left--;
              if (Tick) stall_total++;
            end else begin
              OutReady = 1'b1;
              if (Tick) begin
                void'(exp_q.pop_front());
                void'(addr_q.pop_front());
                words++;
              end
            end
          end
        end else begin
          OutReady = 1'($urandom_range(0, 1));
        end
        if (restart_mid && k == 3) begin
          StartAddr = 8'($urandom);
          Length = 8'($urandom_range(1, 9));
          if (s) start1 = 1'b1; else start0 = 1'b1;
        end
        @(posedge Clock); #1;
        k++;
      end
    end
    chk("fin_cycle", fin_cycle, 1 + mult * int'(len) * (lat + 1) + stall_total);
    chk("word_count", words, len);
    chk("cs_low_cycles", cs_low, mult * int'(len) * lat);
    Tick = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    @(posedge Clock); #1;
    chk("busy_after_fin", s_busy, 0);
    chk("done_after_fin", s_done, 0);
    chk("cs_n_idle", s_cs_n, 1);
    chk("valid_idle", s_valid, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int fin;
    logic [AB-1:0] ra;
    Reset = 1'b1;
    Tick = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    OutReady = 1'b0;
    StartAddr = '0;
    Length = '0;
    for (int i = 0; i < 256; i++) mem[i] = NB'(i + 16'h100);
    #1;
    sel = 1'b0; #0 chk_reset_vals("reset_l2");
    sel = 1'b1; #0 chk_reset_vals("reset_l3");
    @(posedge Clock); @(posedge Clock); #1;
    Reset = 1'b0;

    // Basic burst: words 0x110..0x112, Done in cycle 10.
    run_burst(1'b0, 8'h10, 8'd3, 1'b0, 0, 1'b0, 1'b0, fin);
    chk("basic_done_cycle", fin, 10);

    // Zero length: Done in cycle 1, no select, no valid.
    run_burst(1'b0, 8'($urandom), 8'd0, 1'b0, 0, 1'b0, 1'b0, fin);
    chk("zero_len_done_cycle", fin, 1);

    // Address wrap 0xFE, 0xFF, 0x00.
    run_burst(1'b0, 8'hFE, 8'd3, 1'b0, 0, 1'b0, 1'b0, fin);

    // Stall of 5 cycles on the first word plus an ignored second Start.
    run_burst(1'b0, 8'h40, 8'd4, 1'b0, 5, 1'b0, 1'b1, fin);

    // L=3 with Tick always high, then the same burst with Tick toggling.
    for (int i = 0; i < 256; i++) mem[i] = NB'($urandom);
    ra = 8'($urandom);
    run_burst(1'b1, ra, 8'd2, 1'b0, 0, 1'b0, 1'b0, fin);
    chk("l3_tick_done_cycle", fin, 9);
    run_burst(1'b1, ra, 8'd2, 1'b1, 0, 1'b0, 1'b0, fin);
    chk("l3_toggle_done_cycle", fin, 17);

    // Randomized bursts on both latencies.
    for (int n = 0; n < 12; n++) begin
      bit tg;
      tg = 1'($urandom_range(0, 1));
      run_burst(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 6)),
                tg, 0, !tg, 1'($urandom_range(0, 1)), fin);
    end

    // Reset while waiting on the memory.
    sel = 1'b0;
    StartAddr = 8'h80;
    Length = 8'd4;
    Tick = 1'b1;
    OutReady = 1'b1;
    start0 = 1'b1;
    @(posedge Clock); #1;
    start0 = 1'b0;
    @(posedge Clock); #1;
    chk("mid_wait_cs_n", s_cs_n, 0);
    chk("mid_wait_busy", s_busy, 1);
    #2 Reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(posedge Clock); #1;
    chk("reset_hold_done", s_done, 0);
    @(posedge Clock); #1;
    chk("reset_hold_cs_n", s_cs_n, 1);
    Reset = 1'b0;
    run_burst(1'b0, 8'hC3, 8'd5, 1'b0, 0, 1'b1, 1'b0, fin);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
